// File: rtl/vec_pack_64_if.sv
// rtl/vec_pack_64_if.sv - sample stream in / packed vector out handshake bundle
interface vec_pack_64_if #(
    parameter int LANES = 64,
    parameter int W     = 16,
    parameter int CW    = $clog2(LANES + 1)
);
    logic                 s_valid;
    logic                 s_ready;
    logic [W-1:0]         s_data;
    logic                 s_last;
    logic                 m_valid;
    logic                 m_ready;
    logic [LANES*W-1:0]   m_data;
    logic [CW-1:0]        m_count;

    // slave: the packer's view; master: the sample producer / vector consumer
    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, m_count
    );

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_count
    );
endinterface

// File: rtl/vec_pack_64.sv
// rtl/vec_pack_64.sv - ping-pong stream-to-vector packer feeding the variance stage
module vec_pack_64 #(
    parameter int LANES = 64,
    parameter int W     = 16,
    parameter int CW    = $clog2(LANES + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    vec_pack_64_if.slave  bus
);
    localparam int LW = $clog2(LANES);

    // Bank payloads carry no reset: lanes beyond the count are masked on output.
    logic [LANES*W-1:0] bank_q [2];
    logic [CW-1:0]      count_q [2];
    logic [1:0]         full_q;
    logic               wb_q;
    logic               rb_q;
    logic [LW-1:0]      cnt_q;
    logic [LW-1:0]      cnt_d;

    logic s_fire;
    logic m_fire;
    logic close;

    // Both ready and valid come straight from registers, so there is no
    // combinational path from s_valid or m_ready back out.
    assign bus.s_ready = ~full_q[wb_q];
    assign bus.m_valid = full_q[rb_q];
    assign bus.m_count = count_q[rb_q];

    assign s_fire = bus.s_valid & bus.s_ready;
    assign m_fire = bus.m_valid & bus.m_ready;
    assign close  = s_fire & (bus.s_last | (cnt_q == LW'(LANES - 1)));

    // Lane counter: advance on each accepted sample, restart when the bank closes.
    always_comb begin
        cnt_d = cnt_q;
        if (s_fire) begin
            cnt_d = close ? '0 : cnt_q + 1'b1;
        end
    end

    // Bank bookkeeping. A close always targets wb and a drain always targets rb;
    // they can only coincide when wb != rb because a full wb blocks intake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            wb_q       <= 1'b0;
            rb_q       <= 1'b0;
            full_q     <= 2'b00;
            count_q[0] <= '0;
            count_q[1] <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (close) begin
                full_q[wb_q]  <= 1'b1;
                count_q[wb_q] <= CW'(cnt_q) + CW'(1);
                wb_q          <= ~wb_q;
            end
            if (m_fire) begin
                full_q[rb_q]  <= 1'b0;
                count_q[rb_q] <= '0;
                rb_q          <= ~rb_q;
            end
        end
    end

    // Sample capture into lane cnt of the filling bank.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (s_fire && (cnt_q == LW'(i))) begin
                bank_q[wb_q][i*W +: W] <= bus.s_data;
            end
        end
    end

    // Present the read bank, zeroing lanes at or beyond its count.
    always_comb begin
        bus.m_data = '0;
        for (int i = 0; i < LANES; i++) begin
            if (CW'(i) < count_q[rb_q]) begin
                bus.m_data[i*W +: W] = bank_q[rb_q][i*W +: W];
            end
        end
    end
endmodule

// File: tb/tb_vec_pack_64.sv
// tb/tb_vec_pack_64.sv - directed self-checking bench for vec_pack_64
module tb_vec_pack_64;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;
    int   ready_miss = 0;

    always #5 clk = ~clk;

    vec_pack_64_if #(.LANES(64), .W(16), .CW(7)) bus ();

    vec_pack_64 #(.LANES(64), .W(16), .CW(7)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_vec(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        int lane;
        checks++;
        assert (obs === exp) else begin
            failures++;
            lane = 0;
            for (int i = 63; i >= 0; i--) begin
                if (obs[i*16 +: 16] !== exp[i*16 +: 16]) lane = i;
            end
            $error("FAIL %s lane=%0d observed=%h expected=%h", tag, lane,
                   obs[lane*16 +: 16], exp[lane*16 +: 16]);
        end
    endtask

    function automatic logic [1023:0] mk(input logic [15:0] base, input int n);
        logic [1023:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[i*16 +: 16] = base + 16'(i);
        return v;
    endfunction

    // One sample presented for one cycle; a low s_ready at fire time is a miss.
    task automatic send(input logic [15:0] d, input logic last);
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = last;
        if (bus.s_ready !== 1'b1) ready_miss++;
        cyc();
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        check("rst_s_ready", 64'(bus.s_ready), 64'd1);
        check("rst_m_valid", 64'(bus.m_valid), 64'd0);
        check("rst_m_count", 64'(bus.m_count), 64'd0);
        check_vec("rst_m_data", bus.m_data, '0);

        // Single full vector, continuous with m_ready=1
        bus.m_ready = 1'b1;
        for (int i = 0; i < 63; i++) send(16'(i + 1), 1'b0);
        check("t1_not_yet_valid", 64'(bus.m_valid), 64'd0);
        send(16'h0040, 1'b0);
        check("t1_m_valid", 64'(bus.m_valid), 64'd1);
        check("t1_m_count", 64'(bus.m_count), 64'd64);
        check_vec("t1_m_data", bus.m_data, mk(16'h0001, 64));
        cyc();
        check("t1_drained", 64'(bus.m_valid), 64'd0);
        check("t1_ready_miss", 64'(ready_miss), 64'd0);

        // Backpressure: two full vectors held
        bus.m_ready = 1'b0;
        for (int i = 0; i < 128; i++) send(16'h1000 + 16'(i), 1'b0);
        check("t2_ready_miss", 64'(ready_miss), 64'd0);
        check("t2_s_ready_low", 64'(bus.s_ready), 64'd0);
        check("t2_first_valid", 64'(bus.m_valid), 64'd1);
        check_vec("t2_first_data", bus.m_data, mk(16'h1000, 64));
        bus.m_ready = 1'b1;
        cyc();
        bus.m_ready = 1'b0;
        check("t2_s_ready_back", 64'(bus.s_ready), 64'd1);
        check("t2_second_valid", 64'(bus.m_valid), 64'd1);
        check("t2_second_count", 64'(bus.m_count), 64'd64);
        check_vec("t2_second_data", bus.m_data, mk(16'h1040, 64));
        cyc();
        check_vec("t2_second_held", bus.m_data, mk(16'h1040, 64));
        bus.m_ready = 1'b1;
        cyc();
        bus.m_ready = 1'b0;
        check("t2_all_drained", 64'(bus.m_valid), 64'd0);

        // Early close after 10 samples; stale bank contents must be masked
        for (int i = 0; i < 10; i++) send(16'h0100 + 16'(i), i == 9);
        check("t3_m_valid", 64'(bus.m_valid), 64'd1);
        check("t3_m_count", 64'(bus.m_count), 64'd10);
        check_vec("t3_m_data", bus.m_data, mk(16'h0100, 10));
        bus.m_ready = 1'b1;
        cyc();
        bus.m_ready = 1'b0;
        send(16'h0AAA, 1'b1);
        check("t3_next_count", 64'(bus.m_count), 64'd1);
        check_vec("t3_next_lane0", bus.m_data, mk(16'h0AAA, 1));
        bus.m_ready = 1'b1;
        cyc();
        bus.m_ready = 1'b0;

        // s_last on the 64th sample, then on the 1st sample of the next vector
        for (int i = 0; i < 64; i++) send(16'h2000 + 16'(i), i == 63);
        check("t4_m_count", 64'(bus.m_count), 64'd64);
        check_vec("t4_m_data", bus.m_data, mk(16'h2000, 64));
        bus.m_ready = 1'b1;
        cyc();
        bus.m_ready = 1'b0;
        check("t4_no_empty_vec", 64'(bus.m_valid), 64'd0);
        send(16'h0055, 1'b1);
        check("t4_single_valid", 64'(bus.m_valid), 64'd1);
        check("t4_single_count", 64'(bus.m_count), 64'd1);
        check_vec("t4_single_data", bus.m_data, mk(16'h0055, 1));
        bus.m_ready = 1'b1;
        cyc();
        bus.m_ready = 1'b0;

        // Bank B closes in the same cycle bank A is drained
        for (int i = 0; i < 64; i++) send(16'h3000 + 16'(i), 1'b0);
        for (int i = 0; i < 63; i++) send(16'h4000 + 16'(i), 1'b0);
        check_vec("t5_a_first", bus.m_data, mk(16'h3000, 64));
        bus.m_ready = 1'b1;
        send(16'h403F, 1'b0);
        bus.m_ready = 1'b0;
        check("t5_b_valid", 64'(bus.m_valid), 64'd1);
        check_vec("t5_b_data", bus.m_data, mk(16'h4000, 64));
        check("t5_s_ready_nogap", 64'(bus.s_ready), 64'd1);
        check("t5_ready_miss", 64'(ready_miss), 64'd0);
        bus.m_ready = 1'b1;
        cyc();
        bus.m_ready = 1'b0;
        check("t5_drained", 64'(bus.m_valid), 64'd0);

        // Reset with one held vector and a 30-sample partial fill
        for (int i = 0; i < 64; i++) send(16'h5000 + 16'(i), 1'b0);
        for (int i = 0; i < 30; i++) send(16'h6000 + 16'(i), 1'b0);
        check("t6_held_before", 64'(bus.m_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_m_valid", 64'(bus.m_valid), 64'd0);
        check("t6_rst_m_count", 64'(bus.m_count), 64'd0);
        check("t6_rst_s_ready", 64'(bus.s_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 64; i++) send(16'h7000 + 16'(i), 1'b0);
        check("t6_new_valid", 64'(bus.m_valid), 64'd1);
        check("t6_new_count", 64'(bus.m_count), 64'd64);
        check_vec("t6_new_data", bus.m_data, mk(16'h7000, 64));
        bus.m_ready = 1'b1;
        cyc();
        bus.m_ready = 1'b0;
        check("t6_only_one", 64'(bus.m_valid), 64'd0);
        check("t6_ready_miss", 64'(ready_miss), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
